apb3_cpuif_bridge: RTL

APB3 completer front end that converts APB3 transfers into the single-outstanding request/acknowledge CPU interface used by generated register blocks. It sits between the system APB3 bus (or the bench APB3 driver) and the register block's internal cpuif port. It also performs alignment and range checks and has a response timeout, so the bus never hangs.

---
 rtl/apb3_cpuif_pkg.sv | 24 ++
 rtl/cpuif_timeout_ctr.sv | 27 ++
 rtl/apb3_cpuif_bridge.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/apb3_cpuif_pkg.sv
// Shared types and helpers for the APB3 to cpuif bridge.
package apb3_cpuif_pkg;

   // Bridge FSM state encoding.
   typedef logic [1:0] state_t;
   localparam state_t StIdle = 2'd0;
   localparam state_t StWait = 2'd1;
   localparam state_t StResp = 2'd2;

   // Widest supported data bus; narrower buses use the low bits.
   localparam int unsigned MaxDataWidth = 64;

   // Completion response presented on the APB side.
   typedef struct packed {
      logic [MaxDataWidth-1:0] data;
      logic                    err;
   } resp_t;

   // Byte-address bits that must be zero for an access of data_width bits.
   function automatic int unsigned align_mask(input int unsigned data_width);
      return (data_width / 8) - 1;
   endfunction

endpackage

// File: rtl/cpuif_timeout_ctr.sv
// Counts cycles spent waiting for a cpuif ack and flags expiry.
module cpuif_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntWidth-1:0] cnt_q;

   assign expired = (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));

   // Count up while enabled, saturating at the expiry value.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en && !expired) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/apb3_cpuif_bridge.sv
// APB3 completer that forwards legal transfers to a single-outstanding
// req/ack register-block interface, with alignment, range and timeout checks.
module apb3_cpuif_bridge
   import apb3_cpuif_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_LIMIT     = 'h200,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_psel,
   input  logic                  s_penable,
   input  logic                  s_pwrite,
   input  logic [ADDR_WIDTH-1:0] s_paddr,
   input  logic [DATA_WIDTH-1:0] s_pwdata,
   output logic                  s_pready,
   output logic [DATA_WIDTH-1:0] s_prdata,
   output logic                  s_pslverr,
   output logic                  cpuif_req,
   output logic                  cpuif_req_is_wr,
   output logic [ADDR_WIDTH-1:0] cpuif_addr,
   output logic [DATA_WIDTH-1:0] cpuif_wr_data,
   input  logic                  cpuif_rd_ack,
   input  logic                  cpuif_rd_err,
   input  logic [DATA_WIDTH-1:0] cpuif_rd_data,
   input  logic                  cpuif_wr_ack,
   input  logic                  cpuif_wr_err
);

   localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'(align_mask(DATA_WIDTH));
   localparam logic [ADDR_WIDTH:0]   LimitExt  = (ADDR_WIDTH + 1)'(ADDR_LIMIT);

   state_t                state_q, state_d;
   logic                  req_q, req_d;
   logic                  is_wr_q, is_wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  pready_q, pready_d;
   logic [DATA_WIDTH-1:0] prdata_q;
   logic                  pslverr_q;
   resp_t                 resp_d;
   logic                  addr_ok;
   logic                  ack_match;
   logic                  expired;
   logic [MaxDataWidth-1:0] unused_resp_data;

   assign addr_ok   = ((s_paddr & AlignMask) == '0) && ({1'b0, s_paddr} < LimitExt);
   assign ack_match = is_wr_q ? cpuif_wr_ack : cpuif_rd_ack;
   assign unused_resp_data = resp_d.data;

   if (TIMEOUT_CYCLES > 0) begin : g_timeout
      cpuif_timeout_ctr #(
         .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timeout (
         .clk    (clk),
         .rst    (rst),
         .clr    (state_q != StWait),
         .en     (state_q == StWait),
         .expired(expired)
      );
   end else begin : g_no_timeout
      assign expired = 1'b0;
   end

   // Next-state, request and response selection.
   always_comb begin
      state_d  = state_q;
      req_d    = 1'b0;
      is_wr_d  = is_wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      pready_d = 1'b0;
      resp_d   = '0;
      case (state_q)
         StIdle: begin
            // Only a setup phase starts a transfer; a bare access phase is ignored.
            if (s_psel && !s_penable) begin
               if (addr_ok) begin
                  req_d   = 1'b1;
                  is_wr_d = s_pwrite;
                  addr_d  = s_paddr;
                  wdata_d = s_pwdata;
                  state_d = StWait;
               end else begin
                  pready_d   = 1'b1;
                  resp_d.err = 1'b1;
                  state_d    = StResp;
               end
            end
         end
         StWait: begin
            // A matching ack on the final count beats the timeout.
            if (ack_match) begin
               pready_d    = 1'b1;
               resp_d.data = is_wr_q ? '0 : MaxDataWidth'(cpuif_rd_data);
               resp_d.err  = is_wr_q ? cpuif_wr_err : cpuif_rd_err;
               state_d     = StResp;
            end else if (expired) begin
               pready_d   = 1'b1;
               resp_d.err = 1'b1;
               state_d    = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Registered state and outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         req_q     <= 1'b0;
         is_wr_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         is_wr_q   <= is_wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         pready_q  <= pready_d;
         prdata_q  <= resp_d.data[DATA_WIDTH-1:0];
         pslverr_q <= resp_d.err;
      end
   end

   assign s_pready        = pready_q;
   assign s_prdata        = prdata_q;
   assign s_pslverr       = pslverr_q;
   assign cpuif_req       = req_q;
   assign cpuif_req_is_wr = is_wr_q;
   assign cpuif_addr      = addr_q;
   assign cpuif_wr_data   = wdata_q;

endmodule
